// File: rtl/regfile_param_if.sv
// Register file bus: read addresses from decode, write port from writeback,
// plus soft clear and status flags back to the pipeline.
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
) ();
  logic                       clr;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic                       ready;
  logic                       wr_drop;

  modport master (
    output clr, wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, ready, wr_drop
  );

  modport slave (
    input  clr, wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, ready, wr_drop
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file with an init sequencer (power-up / soft clear),
// optional write-to-read bypass and optional hardwired-zero entry 0.
// One write port shared by the sequencer and the writeback path; the two
// never collide because external writes are only accepted once READY.
module regfile_param #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int NUM_REGS  = 16,
  parameter int NUM_RD    = 2,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1,
  parameter int INIT_MODE = 1
) (
  input  logic            clk,
  input  logic            rst,
  regfile_param_if.slave  bus
);

  typedef enum logic {INIT, READY} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  state_t            state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic              ready_reg;
  logic              drop_reg;

  logic [DATA_W-1:0] mem [NUM_REGS];

  logic              wr_in_range;
  logic              wr_zero;
  logic              wr_open;
  logic              wr_accept;
  logic              wr_discard;
  logic [DATA_W-1:0] init_val;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Write qualification. A write to the hardwired-zero entry while otherwise
  // open is swallowed without flagging a drop.
  assign wr_in_range = {1'b0, bus.wr_addr} < NUM_REGS_W;
  assign wr_zero     = (ZERO_REG != 0) && (bus.wr_addr == '0);
  assign wr_open     = (state_reg == READY) && !bus.clr;
  assign wr_accept   = bus.wr_en && wr_open && wr_in_range && !wr_zero;
  assign wr_discard  = bus.wr_en && !wr_accept && !(wr_open && wr_zero);

  assign init_val = (INIT_MODE != 0) ? DATA_W'(ptr_reg) : '0;

  // Single memory write port: sequencer during INIT, writeback when accepted.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    if (state_reg == INIT && !bus.clr) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_reg;
      mem_wdata = init_val;
    end else if (wr_accept) begin
      mem_we = 1'b1;
    end
  end

  // Storage array; contents are never reset, the sequencer overwrites them.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Init sequencer FSM with registered ready and drop pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= INIT;
      ptr_reg   <= '0;
      ready_reg <= 1'b0;
      drop_reg  <= 1'b0;
    end else begin
      drop_reg <= wr_discard;
      if (bus.clr) begin
        state_reg <= INIT;
        ptr_reg   <= '0;
        ready_reg <= 1'b0;
      end else if (state_reg == INIT) begin
        if (ptr_reg == LAST_ADDR) begin
          ptr_reg   <= '0;
          state_reg <= READY;
          ready_reg <= 1'b1;
        end else begin
          ptr_reg <= ptr_reg + 1'b1;
        end
      end
    end
  end

  assign bus.ready   = ready_reg;
  assign bus.wr_drop = drop_reg;

  // Read ports: independent combinational muxes, so identical addresses on
  // several ports simply return the same value.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = bus.rd_addr[gi*ADDR_W +: ADDR_W];

    // Priority: INIT, out of range, zero entry, bypass, array.
    always_comb begin
      rd = '0;
      if (state_reg == INIT) begin
        rd = '0;
      end else if (!({1'b0, ra} < NUM_REGS_W)) begin
        rd = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd = '0;
      end else if ((BYPASS != 0) && wr_accept && (ra == bus.wr_addr)) begin
        rd = bus.wr_data;
      end else begin
        rd = mem[ra];
      end
    end

    assign bus.rd_data[gi*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two instances (default configuration and a
// 12-entry, no-bypass, no-zero-reg variant) driven with identical stimulus.
// Instance A is checked against a hand-written vector table, then both are
// checked against a behavioural model under async-reset sequences and
// random traffic.
module tb_regfile_param;

  logic clk;
  logic rst;

  logic        clr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  ra0;
  logic [3:0]  ra1;

  int total = 0;
  int bad   = 0;

  regfile_param_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2)) bus_a ();
  regfile_param_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2)) bus_b ();

  assign bus_a.clr     = clr;
  assign bus_a.wr_en   = wr_en;
  assign bus_a.wr_addr = wr_addr;
  assign bus_a.wr_data = wr_data;
  assign bus_a.rd_addr = {ra1, ra0};
  assign bus_b.clr     = clr;
  assign bus_b.wr_en   = wr_en;
  assign bus_b.wr_addr = wr_addr;
  assign bus_b.wr_data = wr_data;
  assign bus_b.rd_addr = {ra1, ra0};

  regfile_param #(
    .DATA_W(32), .ADDR_W(4), .NUM_REGS(16), .NUM_RD(2),
    .BYPASS(1), .ZERO_REG(1), .INIT_MODE(1)
  ) u_a (.clk(clk), .rst(rst), .bus(bus_a));

  regfile_param #(
    .DATA_W(32), .ADDR_W(4), .NUM_REGS(12), .NUM_RD(2),
    .BYPASS(0), .ZERO_REG(0), .INIT_MODE(1)
  ) u_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam int P_N   [2] = '{16, 12};
  localparam bit P_BYP [2] = '{1'b1, 1'b0};
  localparam bit P_ZR  [2] = '{1'b1, 1'b0};

  logic [31:0] m_mem [2][16];
  int          m_cnt [2];
  bit          m_rdy [2];
  bit          m_drop[2];

  function automatic void m_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d]  = 0;
      m_rdy[d]  = 1'b0;
      m_drop[d] = 1'b0;
    end
  endfunction

  function automatic bit m_accepts(input int d);
    return m_rdy[d] && !clr && wr_en && (int'(wr_addr) < P_N[d]) &&
           !(P_ZR[d] && wr_addr == 4'd0);
  endfunction

  function automatic logic [31:0] m_read(input int d, input logic [3:0] a);
    if (!m_rdy[d])                                  return 32'd0;
    if (int'(a) >= P_N[d])                          return 32'd0;
    if (P_ZR[d] && a == 4'd0)                       return 32'd0;
    if (P_BYP[d] && m_accepts(d) && a == wr_addr)   return wr_data;
    return m_mem[d][a];
  endfunction

  function automatic void m_edge(input int d);
    if (clr) begin
      m_drop[d] = wr_en;
      m_rdy[d]  = 1'b0;
      m_cnt[d]  = 0;
    end else if (!m_rdy[d]) begin
      m_mem[d][m_cnt[d]] = 32'(m_cnt[d]);
      m_cnt[d]  = m_cnt[d] + 1;
      m_rdy[d]  = (m_cnt[d] == P_N[d]);
      m_drop[d] = wr_en;
    end else begin
      m_drop[d] = 1'b0;
      if (wr_en) begin
        if (int'(wr_addr) >= P_N[d]) m_drop[d] = 1'b1;
        else if (!(P_ZR[d] && wr_addr == 4'd0)) m_mem[d][wr_addr] = wr_data;
      end
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        clr;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  r0;
    logic [3:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        er;
    logic        ed;
  } vec_t;

  function automatic vec_t mk(input bit c, input bit we, input int wa, input logic [31:0] wd,
                              input int r0, input int r1, input logic [31:0] e0,
                              input logic [31:0] e1, input bit er, input bit ed);
    vec_t v;
    v.clr = c;  v.we = we; v.wa = 4'(wa); v.wd = wd;
    v.r0 = 4'(r0); v.r1 = 4'(r1); v.e0 = e0; v.e1 = e1; v.er = er; v.ed = ed;
    return v;
  endfunction

  // One clock cycle, entered and left at a falling edge with inputs applied.
  // Reads are compared before the rising edge, flags just after it.
  task automatic cycle(input bit use_tab, input vec_t v);
    #1;
    if (use_tab) begin
      check("tab_rd0_a", bus_a.rd_data[31:0],  v.e0);
      check("tab_rd1_a", bus_a.rd_data[63:32], v.e1);
    end else begin
      check("rd0_a", bus_a.rd_data[31:0],  m_read(0, ra0));
      check("rd1_a", bus_a.rd_data[63:32], m_read(0, ra1));
    end
    check("rd0_b", bus_b.rd_data[31:0],  m_read(1, ra0));
    check("rd1_b", bus_b.rd_data[63:32], m_read(1, ra1));
    @(posedge clk);
    m_edge(0);
    m_edge(1);
    #1;
    if (use_tab) begin
      check("tab_ready_a", 32'(bus_a.ready),   32'(v.er));
      check("tab_drop_a",  32'(bus_a.wr_drop), 32'(v.ed));
    end else begin
      check("ready_a", 32'(bus_a.ready),   32'(m_rdy[0]));
      check("drop_a",  32'(bus_a.wr_drop), 32'(m_drop[0]));
    end
    check("ready_b", 32'(bus_b.ready),   32'(m_rdy[1]));
    check("drop_b",  32'(bus_b.wr_drop), 32'(m_drop[1]));
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clr = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 32'd0;
  endtask

  vec_t tab [45];
  vec_t none;

  initial begin
    // Expected values for instance A (16 entries, bypass, zero reg, init i).
    tab[0] = mk(0, 0, 0, 0, 5, 15, 0, 0, 0, 0);
    tab[1] = mk(0, 0, 0, 0, 0, 3,  0, 0, 0, 0);
    tab[2] = mk(0, 0, 0, 0, 5, 15, 0, 0, 0, 0);
    tab[3] = mk(0, 1, 3, 32'h0000DEAD, 3, 3, 0, 0, 0, 1);
    for (int i = 4; i < 15; i++) tab[i] = mk(0, 0, 0, 0, 5, 15, 0, 0, 0, 0);
    tab[15] = mk(0, 0, 0, 0, 5, 15, 0, 0, 1, 0);
    tab[16] = mk(0, 0, 0, 0, 5, 15, 5, 15, 1, 0);
    tab[17] = mk(0, 0, 0, 0, 0, 3, 0, 3, 1, 0);
    tab[18] = mk(0, 1, 7, 32'hCAFEBABE, 7, 7, 32'hCAFEBABE, 32'hCAFEBABE, 1, 0);
    tab[19] = mk(0, 0, 0, 0, 7, 4, 32'hCAFEBABE, 4, 1, 0);
    tab[20] = mk(0, 1, 0, 32'h00001234, 0, 0, 0, 0, 1, 0);
    tab[21] = mk(0, 0, 0, 0, 0, 7, 0, 32'hCAFEBABE, 1, 0);
    tab[22] = mk(0, 1, 4, 32'h44444444, 4, 9, 32'h44444444, 9, 1, 0);
    tab[23] = mk(0, 1, 9, 32'h99999999, 4, 9, 32'h44444444, 32'h99999999, 1, 0);
    tab[24] = mk(0, 0, 0, 0, 4, 9, 32'h44444444, 32'h99999999, 1, 0);
    tab[25] = mk(1, 1, 4, 32'h00000055, 4, 9, 32'h44444444, 32'h99999999, 0, 1);
    for (int i = 26; i < 41; i++) tab[i] = mk(0, 0, 0, 0, 4, 9, 0, 0, 0, 0);
    tab[41] = mk(0, 0, 0, 0, 4, 9, 0, 0, 1, 0);
    tab[42] = mk(0, 0, 0, 0, 4, 9, 4, 9, 1, 0);
    tab[43] = mk(0, 1, 15, 32'hFFFF0000, 15, 7, 32'hFFFF0000, 7, 1, 0);
    tab[44] = mk(0, 1, 13, 32'h0000ABCD, 13, 15, 32'h0000ABCD, 32'hFFFF0000, 1, 0);
    none = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Power-up reset.
    rst = 1'b0;
    idle_inputs();
    ra0 = 4'd5; ra1 = 4'd15;
    m_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready_a", 32'(bus_a.ready),   32'd0);
    check("rst_drop_a",  32'(bus_a.wr_drop), 32'd0);
    check("rst_rd0_a",   bus_a.rd_data[31:0], 32'd0);
    check("rst_ready_b", 32'(bus_b.ready),   32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 45; i++) begin
      clr = tab[i].clr; wr_en = tab[i].we; wr_addr = tab[i].wa; wr_data = tab[i].wd;
      ra0 = tab[i].r0;  ra1 = tab[i].r1;
      cycle(1'b1, tab[i]);
      $display("vec %0d clr=%0b we=%0b wa=%0d wd=%08h rd=%0d,%0d", i,
               tab[i].clr, tab[i].we, tab[i].wa, tab[i].wd, tab[i].r0, tab[i].r1);
    end

    // Out-of-range write on the 12-entry instance: drop flagged, reads 0.
    idle_inputs();
    ra0 = 4'd13; ra1 = 4'd11;
    #1;
    check("oob_drop_b", 32'(bus_b.wr_drop), 32'd1);
    check("oob_rd_b",   bus_b.rd_data[31:0], 32'd0);
    check("pre_rst_ready_a", 32'(bus_a.ready), 32'd1);

    // Async reset while READY: ready drops without a clock edge.
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    check("async_ready_a", 32'(bus_a.ready), 32'd0);
    check("async_ready_b", 32'(bus_b.ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (16) cycle(1'b0, none);
    $display("reset while ready: reinit complete");

    // Async reset mid-INIT at ptr 6, then full re-init and readback.
    clr = 1'b1;
    cycle(1'b0, none);
    clr = 1'b0;
    repeat (6) cycle(1'b0, none);
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    check("midinit_ready_a", 32'(bus_a.ready),   32'd0);
    check("midinit_drop_a",  32'(bus_a.wr_drop), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, none);
      check("reinit_ready_a", 32'(bus_a.ready), (i == 15) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 16; i += 2) begin
      ra0 = 4'(i); ra1 = 4'(i + 1);
      #1;
      check("reinit_val0_a", bus_a.rd_data[31:0],  (i == 0) ? 32'd0 : 32'(i));
      check("reinit_val1_a", bus_a.rd_data[63:32], 32'(i + 1));
      cycle(1'b0, none);
      $display("readback entries %0d,%0d", i, i + 1);
    end

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      clr     = ($urandom_range(0, 39) == 0);
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = $urandom;
      ra0     = 4'($urandom_range(0, 15));
      ra1     = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      cycle(1'b0, none);
      $display("rnd %0d clr=%0b we=%0b wa=%0d wd=%08h rd=%0d,%0d", n,
               clr, wr_en, wr_addr, wr_data, ra0, ra1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
